// File: rtl/keypad_scanner_if.sv
// Keypad scanner bundle: row sense lines in, column strobes and key event out.
// Latency: none, wires only.
// Backpressure: none; keyValid is a single-cycle pulse with no ready return.
interface keypad_scanner_if;
    logic [3:0] rowIn;
    logic [3:0] colOut;
    logic [3:0] keyCode;
    logic       keyValid;
    logic       keyHeld;

    // Scanner side: reads rows, strobes columns, reports keys.
    modport master (
        input  rowIn,
        output colOut,
        output keyCode,
        output keyValid,
        output keyHeld
    );

    // Keypad/consumer side.
    modport slave (
        output rowIn,
        input  colOut,
        input  keyCode,
        input  keyValid,
        input  keyHeld
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column strobe, full-matrix debounce, single-press events.
// Latency: keyValid one cycle after the end-of-scan sample of the DEBOUNCE_SCANS-th identical scan.
// Backpressure: none; keyValid pulses for one cycle and keyCode holds until the next event.
module keypad_scanner #(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              ClkScan,
    input  logic              Reset,
    keypad_scanner_if.master  kp
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_MAX     = DW'(DEBOUNCE_SCANS);

    // IDLE holds the columns released for one cycle after reset so the
    // first scanning cycle starts cleanly on col 0 with a zero settle count.
    typedef enum logic {ST_IDLE, ST_SCAN} state_t;

    state_t          state;
    state_t          stateNxt;
    logic [1:0]      colIdx;
    logic [SW-1:0]   settleCnt;
    logic [15:0]     scratch;
    logic [15:0]     candidate;
    logic [15:0]     accepted;
    logic [DW-1:0]   stableCnt;
    logic [3:0]      colOutComb;
    logic [3:0]      keyCodeReg;
    logic            keyValidReg;

    logic            sampleCycle;
    logic            endOfScan;
    logic [3:0]      rowsNow;
    logic [15:0]     snapshot;
    logic            snapDiff;
    logic [DW-1:0]   stableNxt;
    logic            snapSingle;
    logic [3:0]      snapIdx;

    // State register.
    always_ff @(posedge ClkScan) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // Next state: leave IDLE after one cycle, then scan forever.
    always_comb begin
        stateNxt = state;
        case (state)
            ST_IDLE: stateNxt = ST_SCAN;
            ST_SCAN: stateNxt = ST_SCAN;
            default: stateNxt = ST_IDLE;
        endcase
    end

    // Column strobe: all released while idle, otherwise one-cold on colIdx.
    always_comb begin
        colOutComb = 4'b1111;
        if (state == ST_SCAN) begin
            colOutComb = ~(4'b1000 >> colIdx);
        end
    end

    // rowIn[3] is row 0, so reverse while inverting to make bit r = row r.
    assign rowsNow     = {~kp.rowIn[0], ~kp.rowIn[1], ~kp.rowIn[2], ~kp.rowIn[3]};
    assign sampleCycle = (state == ST_SCAN) && (settleCnt == SETTLE_LAST);
    assign endOfScan   = sampleCycle && (colIdx == 2'd3);
    assign snapshot    = {rowsNow, scratch[11:0]};
    assign snapDiff    = (snapshot != candidate);
    assign snapSingle  = (snapshot != 16'h0) && ((snapshot & (snapshot - 16'd1)) == 16'h0);

    // Debounce count for the scan completing now; saturates at DEBOUNCE_SCANS.
    always_comb begin
        stableNxt = DW'(1);
        if (!snapDiff) begin
            stableNxt = (stableCnt == DEB_MAX) ? DEB_MAX : DW'(stableCnt + 1'b1);
        end
    end

    // Bit index of the pressed key; only meaningful when snapSingle.
    always_comb begin
        snapIdx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (snapshot[i]) begin
                snapIdx = 4'(i);
            end
        end
    end

    // Settle counter and column index; both wrap with no gap between scans.
    always_ff @(posedge ClkScan) begin
        if (Reset) begin
            settleCnt <= '0;
            colIdx    <= 2'd0;
        end else if (state == ST_SCAN) begin
            if (settleCnt == SETTLE_LAST) begin
                settleCnt <= '0;
                colIdx    <= colIdx + 2'd1;
            end else begin
                settleCnt <= settleCnt + 1'b1;
            end
        end
    end

    // Capture the active column's rows on its last settle cycle.
    always_ff @(posedge ClkScan) begin
        if (Reset) begin
            scratch <= 16'h0;
        end else if (sampleCycle) begin
            scratch[{colIdx, 2'b00} +: 4] <= rowsNow;
        end
    end

    // Debounce: a differing snapshot restarts the count, enough repeats accept it.
    always_ff @(posedge ClkScan) begin
        if (Reset) begin
            candidate <= 16'h0;
            stableCnt <= '0;
            accepted  <= 16'h0;
        end else if (endOfScan) begin
            candidate <= snapshot;
            stableCnt <= stableNxt;
            if (stableNxt == DEB_MAX) begin
                accepted <= snapshot;
            end
        end
    end

    // Key event: only a single key accepted straight after an all-clear snapshot.
    always_ff @(posedge ClkScan) begin
        if (Reset) begin
            keyValidReg <= 1'b0;
            keyCodeReg  <= 4'h0;
        end else begin
            keyValidReg <= 1'b0;
            if (endOfScan && (stableNxt == DEB_MAX) && (accepted == 16'h0) && snapSingle) begin
                keyValidReg <= 1'b1;
                keyCodeReg  <= snapIdx;
            end
        end
    end

    assign kp.colOut   = colOutComb;
    assign kp.keyCode  = keyCodeReg;
    assign kp.keyValid = keyValidReg;
    assign kp.keyHeld  = (accepted != 16'h0);

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural 4x4 key matrix.
// Latency: expected key events carry their cycle relative to the first col-0 cycle.
// Backpressure: none; every keyValid cycle pops exactly one expected event.
module tb_keypad_scanner;

    localparam int SETTLE = 4;
    localparam int DEB    = 3;

    logic ClkScan = 1'b0;
    logic Reset   = 1'b1;

    keypad_scanner_if kp_if ();

    keypad_scanner #(
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .ClkScan(ClkScan),
        .Reset  (Reset),
        .kp     (kp_if)
    );

    always #5 ClkScan = ~ClkScan;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] keys = 16'h0;
    logic [3:0]  rowModel;
    int          cyc = 0;
    int          t0 = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    // Key matrix: a held key at (col c, row r) pulls rowIn[3-r] low while col c is strobed.
    always_comb begin
        rowModel = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[c*4 + r] && (kp_if.colOut[3-c] == 1'b0)) begin
                    rowModel[3-r] = 1'b0;
                end
            end
        end
    end
    assign kp_if.rowIn = rowModel;

    always @(posedge ClkScan) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every keyValid cycle must match the oldest expected event, code and cycle.
    always @(negedge ClkScan) begin
        if (kp_if.keyValid === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("unexpected_valid", 32'(kp_if.keyValid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("valid_code", 32'(kp_if.keyCode), 32'(e.code));
                check_val("valid_cycle", 32'(cyc - t0), 32'(e.cyc));
            end
        end
    end

    task automatic wait_until(input int n);
        while ((cyc - t0) < n) @(negedge ClkScan);
    endtask

    // Assert reset for two edges, check reset outputs, release, and mark cycle 0.
    task automatic do_reset();
        @(negedge ClkScan);
        Reset = 1'b1;
        @(negedge ClkScan);
        check_val("rst_colOut", 32'(kp_if.colOut), 32'hF);
        check_val("rst_keyHeld", 32'(kp_if.keyHeld), 32'd0);
        check_val("rst_keyCode", 32'(kp_if.keyCode), 32'd0);
        check_val("rst_keyValid", 32'(kp_if.keyValid), 32'd0);
        @(negedge ClkScan);
        Reset = 1'b0;
        @(negedge ClkScan);
        t0 = cyc;
        check_val("first_col", 32'(kp_if.colOut), 32'h7);
    endtask

    initial begin
        exp_t e;
        logic [3:0] ec;

        // 1: idle rows, column sequence and no activity.
        do_reset();
        for (int n = 0; n < 32; n++) begin
            wait_until(n);
            ec = 4'b1000 >> ((n / SETTLE) % 4);
            ec = ~ec;
            check_val("col_seq", 32'(kp_if.colOut), 32'(ec));
        end
        wait_until(48);
        check_val("idle_keyHeld", 32'(kp_if.keyHeld), 32'd0);

        // 2: col 1 row 2 pressed at a scan boundary.
        do_reset();
        keys = 16'h0040;
        e.code = 4'h6; e.cyc = 48; sb.push_back(e);
        wait_until(49);
        check_val("press6_code", 32'(kp_if.keyCode), 32'h6);
        check_val("press6_held", 32'(kp_if.keyHeld), 32'd1);

        // 3: hold to scan 10, release, then press col 3 row 0.
        wait_until(160);
        keys = 16'h0;
        wait_until(207);
        check_val("release_held_before", 32'(kp_if.keyHeld), 32'd1);
        wait_until(208);
        check_val("release_held_after", 32'(kp_if.keyHeld), 32'd0);
        keys = 16'h1000;
        e.code = 4'hC; e.cyc = 256; sb.push_back(e);
        wait_until(257);
        check_val("pressC_code", 32'(kp_if.keyCode), 32'hC);

        // 4: release, bounce key 9 on alternate scans, then hold steady.
        wait_until(272);
        keys = 16'h0;
        wait_until(320);
        check_val("pre_bounce_held", 32'(kp_if.keyHeld), 32'd0);
        for (int s = 20; s < 26; s++) begin
            wait_until(16 * s);
            keys = (s % 2 == 0) ? 16'h0200 : 16'h0000;
        end
        wait_until(416);
        keys = 16'h0200;
        e.code = 4'h9; e.cyc = 464; sb.push_back(e);
        wait_until(465);
        check_val("bounce_code", 32'(kp_if.keyCode), 32'h9);

        // 5: ghost pair 1+5, then drop to key 1 without going through zero.
        wait_until(512);
        keys = 16'h0;
        wait_until(576);
        keys = 16'h0022;
        wait_until(625);
        check_val("ghost_code", 32'(kp_if.keyCode), 32'h9);
        check_val("ghost_held", 32'(kp_if.keyHeld), 32'd1);
        wait_until(640);
        keys = 16'h0002;
        wait_until(689);
        check_val("rollover_code", 32'(kp_if.keyCode), 32'h9);
        check_val("rollover_held", 32'(kp_if.keyHeld), 32'd1);

        // 6: reset mid-column with key 1 accepted and still held.
        wait_until(705);
        do_reset();
        e.code = 4'h1; e.cyc = 48; sb.push_back(e);
        wait_until(60);
        check_val("post_rst_code", 32'(kp_if.keyCode), 32'h1);
        check_val("post_rst_held", 32'(kp_if.keyHeld), 32'd1);
        wait_until(100);
        check_val("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side companion to the four-digit multiplexed display driver. The display driver strobes one-cold anodes and drives segments; this block strobes one-cold column lines on a 4x4 matrix keypad and reads back the row lines. It debounces the full key matrix and reports single key presses as a 4-bit code with a one-cycle valid pulse. It runs on its own slow scan clock, in the same way the display driver runs on its display clock.

## Interface

Parameters:
- SETTLE_CYCLES, default 1000: clock cycles each column is driven before its rows are sampled; minimum 2.
- DEBOUNCE_SCANS, default 4: consecutive identical full-matrix scans required before a snapshot is accepted; minimum 1.

Ports:
- ClkScan  input  1  scan clock; all logic on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- rowIn  input  4  row lines, active-low (pulled up externally); rowIn[3] is row 0, rowIn[0] is row 3.
- colOut  output  4  column strobes, one-cold.
- keyCode  output  4  code of the last accepted key, {col[1:0], row[1:0]}.
- keyValid  output  1  one-cycle pulse when keyCode is updated.
- keyHeld  output  1  high while the accepted snapshot has at least one key down.

## Operation

- Column sequence: 4'b0111 (col 0), 4'b1011 (col 1), 4'b1101 (col 2), 4'b1110 (col 3), then back to col 0. This matches the anode order of the display driver.
- Each column is driven for exactly SETTLE_CYCLES cycles. The settle counter runs from 0 to SETTLE_CYCLES-1.
- On the last settle cycle of column c, the block samples ~rowIn into snapshot bits [c*4 +: 4]. Bit c*4+r is row r.
- End of scan is the col-3 sample cycle. At end of scan, the completed 16-bit snapshot is compared with the candidate register:
  - If it differs: the candidate is loaded with the new snapshot and stableCnt is set to 1.
  - If it is equal: stableCnt increments, saturating at DEBOUNCE_SCANS.
  - When stableCnt reaches DEBOUNCE_SCANS on this update, the candidate is copied to the accepted snapshot.
- On every update of the accepted snapshot, the outputs are evaluated against the previous accepted value:
  - Previous accepted was all-zero and the new value has exactly one bit set: keyCode is set to that bit index and keyValid pulses.
  - New value has two or more bits set (ghosting): no event, keyCode is unchanged, keyHeld = 1.
  - New value is zero: release, no event, keyHeld = 0.
  - Previous accepted was nonzero and the new value is a different single key (roll-over without release): no event. A new press requires an accepted all-zero snapshot first.
- keyHeld always equals (accepted != 0).
- Internal state: colIdx (2 bits), settle counter, 16-bit scratch snapshot, candidate, stableCnt, accepted.

## Timing

- Reset values: colOut = 4'b1111, keyCode = 4'h0, keyValid = 0, keyHeld = 0. Candidate, accepted and scratch are all cleared, and stableCnt = 0.
- First cycle after Reset deasserts: colOut = 4'b0111 and the settle count is 0.
- Scan period is 4*SETTLE_CYCLES cycles. colOut changes on the cycle after each column's sample cycle.
- Latency from a stable press to keyValid:
  - keyValid rises in the cycle after the end-of-scan sample of the DEBOUNCE_SCANS-th identical scan.
  - If the press is stable before the first column of a scan, that scan counts.
  - If the press appears mid-scan, the partial scan counts as a differing snapshot, and DEBOUNCE_SCANS further scans are then needed.
- keyValid is high for exactly one cycle. keyCode is valid from that cycle and holds until the next event.
- A bounce that alters any single scan's snapshot restarts the debounce count (stableCnt = 1).
- Reset asserted mid-scan: all state returns to reset values on the next edge, and the partial snapshot is discarded.
- Both the settle counter and colIdx wrap modulo their ranges; there is no idle gap between scans.

## Test plan

Run with SETTLE_CYCLES = 4 and DEBOUNCE_SCANS = 3 (scan period 16 cycles).

1. Reset, rows idle at 4'b1111:
   - During reset, colOut = 1111.
   - After reset, colOut cycles 0111/1011/1101/1110, four cycles each.
   - keyValid never asserts and keyHeld = 0.
2. Press col 1, row 2 (rowIn[1] = 0 while colOut = 1011), applied at a scan boundary:
   - keyValid pulses once, in the cycle after the 3rd end-of-scan sample (cycle 48 after the first col-0 cycle).
   - keyCode = 4'h6 and keyHeld = 1.
3. Hold the key for 10 scans, then release:
   - No further keyValid pulses while held.
   - keyHeld falls 3 scans after release.
   - Pressing col 3, row 0 afterwards gives keyValid with keyCode = 4'hC.
4. Bounce: toggle the key on alternate scans for 6 scans, then hold it steady:
   - No keyValid during the bounce.
   - keyValid fires 3 scans after the key becomes steady.
5. Two keys at once (codes 1 and 5):
   - No keyValid, keyCode unchanged, keyHeld = 1.
   - Release one key without going to zero: still no event.
6. Assert Reset while a key is accepted and mid-column:
   - Next cycle: colOut = 1111, keyHeld = 0, keyCode = 0.
   - If the key is still held after reset, keyValid fires again after 3 full scans.
